// File: rtl/plu_pkg.sv
// Shared helpers for the PLU dot-product pipeline: sizing, lane slicing and
// signed saturation.
`define PLU_LANE(vec, idx, w) vec[(idx)*(w) +: (w)]

package plu_pkg;

    localparam int SAT_W = 256;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Clamp a sign-extended value to the range of a signed width-bit number.
    function automatic logic signed [SAT_W-1:0] sat_signed(input logic signed [SAT_W-1:0] value,
                                                            input int width);
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        logic signed [SAT_W-1:0] res;
        max_v = $signed((SAT_W'(1'b1) << (width - 1)) - SAT_W'(1'b1));
        min_v = ~max_v;
        if (value > max_v) begin
            res = max_v;
        end else if (value < min_v) begin
            res = min_v;
        end else begin
            res = value;
        end
        return res;
    endfunction

endpackage

// File: rtl/plu_adder_tree.sv
// Registered signed adder tree: one pairwise-add level per stage, each level one
// bit wider, with valid/last/relu sidebands shifting alongside under a common enable.
module plu_adder_tree
    import plu_pkg::*;
#(
    parameter int N    = 4,
    parameter int IN_W = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         in_valid,
    input  logic                         in_last,
    input  logic                         in_relu,
    input  logic [N*IN_W-1:0]            in_data,
    output logic                         out_valid,
    output logic                         out_last,
    output logic                         out_relu,
    output logic [IN_W+clog2(N)-1:0]     out_sum
);

    localparam int L = clog2(N);

    for (genvar g = 0; g < L; g++) begin : g_lvl
        localparam int CNT = N >> (g + 1);
        localparam int IW  = IN_W + g;
        localparam int OW  = IW + 1;

        logic [2*CNT*IW-1:0] src_s;
        logic                src_valid_s;
        logic                src_last_s;
        logic                src_relu_s;
        logic [CNT*OW-1:0]   nxt_s;
        logic [CNT*OW-1:0]   sum_r;
        logic                valid_r;
        logic                last_r;
        logic                relu_r;

        if (g == 0) begin : g_head
            assign src_s       = in_data;
            assign src_valid_s = in_valid;
            assign src_last_s  = in_last;
            assign src_relu_s  = in_relu;
        end else begin : g_body
            assign src_s       = g_lvl[g-1].sum_r;
            assign src_valid_s = g_lvl[g-1].valid_r;
            assign src_last_s  = g_lvl[g-1].last_r;
            assign src_relu_s  = g_lvl[g-1].relu_r;
        end

        // Pairwise sign-extended sums for this level.
        always_comb begin
            nxt_s = '0;
            for (int j = 0; j < CNT; j++) begin
                nxt_s[j*OW +: OW] = OW'($signed(src_s[2*j*IW +: IW]))
                                  + OW'($signed(src_s[(2*j+1)*IW +: IW]));
            end
        end

        // Level register; frozen together with the rest of the pipe.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sum_r   <= '0;
                valid_r <= 1'b0;
                last_r  <= 1'b0;
                relu_r  <= 1'b0;
            end else if (en) begin
                sum_r   <= nxt_s;
                valid_r <= src_valid_s;
                last_r  <= src_last_s;
                relu_r  <= src_relu_s;
            end
        end
    end

    assign out_sum   = g_lvl[L-1].sum_r;
    assign out_valid = g_lvl[L-1].valid_r;
    assign out_last  = g_lvl[L-1].last_r;
    assign out_relu  = g_lvl[L-1].relu_r;

endmodule

// File: rtl/plu_dot_pipe.sv
// N-lane signed dot product: input regs, products, adder tree, multi-beat
// accumulator, then rescale / saturate / ReLU into a held output register.
module plu_dot_pipe
    import plu_pkg::*;
#(
    parameter int N      = 4,
    parameter int DATA_W = 32,
    parameter int FRAC_W = 0,
    parameter int ACC_W  = 2*DATA_W + clog2(N) + 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*DATA_W-1:0]   in_w,
    input  logic [N*DATA_W-1:0]   in_a,
    input  logic                  in_last,
    input  logic                  in_relu_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_sat
);

    localparam int L      = clog2(N);
    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = PROD_W + L;

    logic                  advance_s;
    logic                  v0_r, last0_r, relu0_r;
    logic [N*DATA_W-1:0]   w0_r, a0_r;
    logic [N*PROD_W-1:0]   prod_s, prod_r;
    logic                  v1_r, last1_r, relu1_r;
    logic                  tv_s, tl_s, tr_s;
    logic [SUM_W-1:0]      tsum_s;
    logic [ACC_W-1:0]      acc_r, acc_base_s, acc_next_s;
    logic                  first_r, va_r, lasta_r, relua_r;
    logic signed [SAT_W-1:0] acc_ext_s, shifted_s, sat_s;
    logic                  clip_s;
    logic [DATA_W-1:0]     res_s;
    logic                  out_valid_r, out_sat_r;
    logic [DATA_W-1:0]     out_data_r;

    // The whole pipe moves only when the output slot is free or being drained.
    assign advance_s = !out_valid_r || out_ready;
    assign in_ready  = rst_n && advance_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_sat   = out_sat_r;

    // S0: input capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v0_r    <= 1'b0;
            last0_r <= 1'b0;
            relu0_r <= 1'b0;
            w0_r    <= '0;
            a0_r    <= '0;
        end else if (advance_s) begin
            v0_r    <= in_valid;
            last0_r <= in_valid && in_last;
            relu0_r <= in_valid && in_relu_en;
            w0_r    <= in_w;
            a0_r    <= in_a;
        end
    end

    // Per-lane signed products at full double width.
    always_comb begin
        prod_s = '0;
        for (int i = 0; i < N; i++) begin
            prod_s[i*PROD_W +: PROD_W] = PROD_W'($signed(`PLU_LANE(w0_r, i, DATA_W)))
                                       * PROD_W'($signed(`PLU_LANE(a0_r, i, DATA_W)));
        end
    end

    // S1: product register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_r    <= 1'b0;
            last1_r <= 1'b0;
            relu1_r <= 1'b0;
            prod_r  <= '0;
        end else if (advance_s) begin
            v1_r    <= v0_r;
            last1_r <= last0_r;
            relu1_r <= relu0_r;
            prod_r  <= prod_s;
        end
    end

    plu_adder_tree #(
        .N    (N),
        .IN_W (PROD_W)
    ) u_tree (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (advance_s),
        .in_valid  (v1_r),
        .in_last   (last1_r),
        .in_relu   (relu1_r),
        .in_data   (prod_r),
        .out_valid (tv_s),
        .out_last  (tl_s),
        .out_relu  (tr_s),
        .out_sum   (tsum_s)
    );

    // First beat of a vector starts from zero instead of the previous total.
    always_comb begin
        acc_base_s = first_r ? '0 : acc_r;
        acc_next_s = acc_base_s + ACC_W'($signed(tsum_s));
    end

    // SA: accumulator, wraps modulo 2^ACC_W.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r   <= '0;
            first_r <= 1'b1;
            va_r    <= 1'b0;
            lasta_r <= 1'b0;
            relua_r <= 1'b0;
        end else if (advance_s) begin
            va_r    <= tv_s;
            lasta_r <= tv_s && tl_s;
            relua_r <= tr_s;
            if (tv_s) begin
                acc_r   <= acc_next_s;
                first_r <= tl_s;
            end
        end
    end

    // Rescale, clip to DATA_W and optionally clamp negatives to zero.
    always_comb begin
        acc_ext_s = SAT_W'($signed(acc_r));
        shifted_s = acc_ext_s >>> FRAC_W;
        sat_s     = sat_signed(shifted_s, DATA_W);
        clip_s    = (sat_s != shifted_s);
        res_s     = sat_s[DATA_W-1:0];
        if (relua_r && res_s[DATA_W-1]) begin
            res_s = '0;
        end else begin
            res_s = res_s;
        end
    end

    // SO: only a completed vector loads the output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_sat_r   <= 1'b0;
        end else if (advance_s) begin
            if (va_r && lasta_r) begin
                out_valid_r <= 1'b1;
                out_data_r  <= res_s;
                out_sat_r   <= clip_s;
            end else begin
                out_valid_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_plu_dot_pipe.sv
// Scoreboard bench for plu_dot_pipe: two instances (FRAC_W=0 and FRAC_W=8) share
// stimulus; a dot-product reference model fills queues that a monitor drains.
module tb_plu_dot_pipe;

    localparam int N  = 4;
    localparam int DW = 16;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sat;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic [N*DW-1:0] in_w = '0;
    logic [N*DW-1:0] in_a = '0;
    logic            in_last = 1'b0;
    logic            in_relu_en = 1'b0;
    logic            out_ready = 1'b1;
    logic            in_ready0, in_ready8;
    logic            out_valid0, out_valid8;
    logic [DW-1:0]   out_data0, out_data8;
    logic            out_sat0, out_sat8;

    int checks = 0;
    int errors = 0;
    int ready_mode = 0;
    int cyc = 0;
    exp_t q0[$];
    exp_t q8[$];
    longint part_sum = 0;
    int bw[N];
    int ba[N];
    bit hold[2];
    logic [DW-1:0] held_data[2];
    logic held_sat[2];

    plu_dot_pipe #(.N(N), .DATA_W(DW), .FRAC_W(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_w(in_w), .in_a(in_a), .in_last(in_last), .in_relu_en(in_relu_en),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_sat(out_sat0)
    );

    plu_dot_pipe #(.N(N), .DATA_W(DW), .FRAC_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
        .in_w(in_w), .in_a(in_a), .in_last(in_last), .in_relu_en(in_relu_en),
        .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8), .out_sat(out_sat8)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: full-precision sum, shift, clip to 16 bits, optional ReLU.
    function automatic exp_t model(input longint sum, input int frac, input bit relu);
        longint r;
        exp_t e;
        r = sum >>> frac;
        e.sat = 1'b0;
        if (r > 64'sd32767) begin
            r = 64'sd32767;
            e.sat = 1'b1;
        end else if (r < -64'sd32768) begin
            r = -64'sd32768;
            e.sat = 1'b1;
        end
        if (relu && r < 0) r = 0;
        e.data = DW'(r);
        return e;
    endfunction

    function automatic int rnd_val();
        logic [DW-1:0] t;
        case ($urandom_range(0, 4))
            0: return 32767;
            1: return -32768;
            2: return int'($urandom_range(0, 20)) - 10;
            default: begin
                t = DW'($urandom);
                return int'($signed(t));
            end
        endcase
    endfunction

    // Present bw/ba as one beat, wait (bounded) for acceptance, then update the model.
    task automatic send_beat(input bit last, input bit relu);
        bit acc;
        int tmo;
        for (int i = 0; i < N; i++) begin
            in_w[i*DW +: DW] = DW'(bw[i]);
            in_a[i*DW +: DW] = DW'(ba[i]);
        end
        in_last = last;
        in_relu_en = relu;
        in_valid = 1'b1;
        acc = 1'b0;
        tmo = 0;
        while (!acc && tmo < 200) begin
            @(negedge clk);
            acc = in_ready0;
            @(posedge clk);
            #1;
            tmo++;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        in_relu_en = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no in_ready, expected accept within 200 cycles");
        end else begin
            for (int i = 0; i < N; i++) part_sum += longint'(bw[i]) * longint'(ba[i]);
            if (last) begin
                q0.push_back(model(part_sum, 0, relu));
                q8.push_back(model(part_sum, 8, relu));
                part_sum = 0;
            end
        end
    endtask

    task automatic fill(input int w, input int a);
        for (int i = 0; i < N; i++) begin
            bw[i] = w;
            ba[i] = a;
        end
    endtask

    task automatic drain();
        int tmo;
        tmo = 0;
        while ((q0.size() != 0 || q8.size() != 0) && tmo < 300) begin
            @(posedge clk);
            #1;
            tmo++;
        end
        if (q0.size() != 0 || q8.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d results pending, expected 0", q0.size() + q8.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic mon(input int p, input logic v, input logic [DW-1:0] d, input logic s,
                       input logic rdy);
        exp_t e;
        string tag;
        tag = (p == 0) ? "f0" : "f8";
        check({"in_ready_", tag}, 32'(rdy), 32'(!(v && !out_ready)));
        if (hold[p]) begin
            check({"stall_valid_", tag}, 32'(v), 32'd1);
            check({"stall_data_", tag}, 32'(d), 32'(held_data[p]));
            check({"stall_sat_", tag}, 32'(s), 32'(held_sat[p]));
        end
        hold[p] = v && !out_ready;
        held_data[p] = d;
        held_sat[p] = s;
        if (v && out_ready) begin
            if ((p == 0 && q0.size() == 0) || (p == 8 && q8.size() == 0) ||
                (p == 1 && q8.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_%s: got data %0h, expected no output", tag, d);
            end else begin
                e = (p == 0) ? q0.pop_front() : q8.pop_front();
                check({"data_", tag}, 32'(d), 32'(e.data));
                check({"sat_", tag}, 32'(s), 32'(e.sat));
            end
        end
    endtask

    // Monitor: inputs change just after posedge, so negedge sees settled values.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold[0] = 1'b0;
            hold[1] = 1'b0;
            if (cyc > 2) begin
                check("in_ready_reset", 32'(in_ready0), 32'd0);
            end
        end else begin
            mon(0, out_valid0, out_data0, out_sat0, in_ready0);
            mon(1, out_valid8, out_data8, out_sat8, in_ready8);
        end
    end

    // Downstream ready pattern.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = (cyc % 3 == 0);
                2: out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b1;
            endcase
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected completion within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        bit rl;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid0), 32'd0);
        check("reset_out_data", 32'(out_data0), 32'd0);
        check("reset_out_sat", 32'(out_sat0), 32'd0);
        check("reset_in_ready", 32'(in_ready0), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic dot product and its latency
        bw = '{1, 2, 3, 4};
        ba = '{5, 6, 7, 8};
        send_beat(1'b1, 1'b1);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check("latency_valid", 32'(out_valid0), 32'(i == 6));
        end
        drain();

        // Negative result with and without ReLU
        bw = '{-1, -2, -3, -4};
        send_beat(1'b1, 1'b1);
        send_beat(1'b1, 1'b0);
        drain();

        // Three-beat vector
        fill(2, 1);
        send_beat(1'b0, 1'b0);
        send_beat(1'b0, 1'b0);
        send_beat(1'b1, 1'b0);
        drain();

        // Saturation both ways, and the fractional rescale case
        fill(32767, 32767);
        send_beat(1'b1, 1'b0);
        fill(32767, -32768);
        send_beat(1'b1, 1'b0);
        fill(16'h0100, 16'h0200);
        send_beat(1'b1, 1'b0);
        drain();

        // Backpressure with results 1..8
        ready_mode = 1;
        for (int k = 1; k <= 8; k++) begin
            bw = '{1, 0, 0, 0};
            ba = '{k, 0, 0, 0};
            send_beat(1'b1, 1'b0);
        end
        drain();
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of a vector
        fill(3, 5);
        send_beat(1'b0, 1'b0);
        send_beat(1'b0, 1'b0);
        rst_n = 1'b0;
        part_sum = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midreset_out_valid", 32'(out_valid0), 32'd0);
        @(posedge clk);
        #1;
        fill(1, 1);
        send_beat(1'b1, 1'b0);
        drain();

        // Randomized multi-beat vectors with random backpressure
        ready_mode = 2;
        for (int v = 0; v < 40; v++) begin
            nb = $urandom_range(1, 3);
            rl = 1'($urandom_range(0, 1));
            for (int b = 0; b < nb; b++) begin
                for (int i = 0; i < N; i++) begin
                    bw[i] = rnd_val();
                    ba[i] = rnd_val();
                end
                send_beat(b == nb - 1, rl);
            end
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
